// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands through one shared 4-bit ripple-carry slice,
// one nibble per clock, least-significant nibble first.
// The carry between nibbles lives in a register.
// Operands arrive on a valid/ready handshake, and results leave on a second
// valid/ready handshake.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' port.
// When sub=1 the block computes a - b through the same slice.

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Number of nibble steps; derived from WIDTH, never overridden.
  localparam int NIBBLES = WIDTH / 4;
  // The index register is at least one bit wide, even when NIBBLES == 1.
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The shared 4-bit ripple-carry slice: {cout, s} = x + y + c.
  function automatic logic [4:0] add_nibble(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       c
  );
    logic [4:0] acc;
    logic       carry;
    carry = c;
    for (int k = 0; k < 4; k++) begin
      acc[k] = x[k] ^ y[k] ^ carry;
      carry  = (x[k] & y[k]) | (x[k] & carry) | (y[k] & carry);
    end
    acc[4] = carry;
    return acc;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_last;
  logic              w_release;
  logic [IDX_W+1:0]  w_base;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [3:0]        w_b_eff;
  logic [4:0]        w_slice;
  logic              w_carry_load;

`ifdef SERIAL_ADD_SUB_EN
  logic              r_sub;
`endif

  // Handshake qualifiers are decoded from the current state only.
  assign w_accept  = (r_state == S_IDLE) & in_valid;
  assign w_release = (r_state == S_DONE) & out_ready;
  assign w_last    = (r_idx == LAST_IDX);

  // Select the nibble pair for the current step from the captured operands.
  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1: invert B per nibble and seed the carry with 1.
  assign w_b_eff      = r_sub ? ~w_b_nib : w_b_nib;
  assign w_carry_load = sub ? 1'b1 : cin;
`else
  assign w_b_eff      = w_b_nib;
  assign w_carry_load = cin;
`endif

  assign w_slice = add_nibble(w_a_nib, w_b_eff, r_carry);

  // Outputs come only from registers or from the state decode.
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last nibble,
  // and DONE -> IDLE once the consumer takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture and the per-nibble datapath (index, carry, sum nibbles).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_carry_load;
            r_idx   <= '0;
            r_sum   <= '0;
          end else begin
            r_idx   <= r_idx;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= w_slice[3:0];
          r_carry            <= w_slice[4];
          // The index wraps to 0 after the top nibble instead of overrunning.
          if (w_last) begin
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        S_DONE: begin
          r_sum <= r_sum;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_SUB_EN
  // The operation mode is captured together with the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= sub;
    end else begin
      r_sub <= r_sub;
    end
  end
`endif

  // Result handshake: the final carry goes to cout, and out_valid rises with the
  // last nibble and stays high until the consumer accepts the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_last) begin
            r_cout      <= w_slice[4];
            r_out_valid <= 1'b1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_cout <= 1'b0;
          end else begin
            r_cout <= r_cout;
          end
          r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
